// File: rtl/mm_router_pkg.sv
// Shared definitions for the memory-map router: slave indices, the default
// address map and the FSM state encoding.
package mm_router_pkg;

    // Slave port indices of the default PLP memory map
    localparam int MM_ROM       = 0;
    localparam int MM_RAM       = 1;
    localparam int MM_UART      = 2;
    localparam int MM_SWITCHES  = 3;
    localparam int MM_LEDS      = 4;
    localparam int MM_GPIO      = 5;
    localparam int MM_VGA       = 6;
    localparam int MM_PLPID     = 7;
    localparam int MM_TIMER     = 8;
    localparam int MM_SSEG      = 9;
    localparam int MM_BOT_UART0 = 10;
    localparam int MM_BOT_UART1 = 11;

    localparam int MM_NSLV_DEF = 12;

    // Default base table, slave 0 in the least significant word.
    localparam logic [MM_NSLV_DEF*32-1:0] MM_DEF_BASE = {
        32'hf0900000,   // plpbot uart 1
        32'hf0800000,   // plpbot uart 0
        32'hf0700000,   // seven segment
        32'hf0600000,   // timer
        32'hf0500000,   // plpid
        32'hf0400000,   // vga
        32'hf0300000,   // gpio
        32'hf0200000,   // leds
        32'hf0100000,   // switches
        32'hf0000000,   // uart
        32'h10000000,   // sram
        32'h00000000    // rom
    };

    // Default offset masks: set bits are passed through as the slave offset.
    localparam logic [MM_NSLV_DEF*32-1:0] MM_DEF_MASK = {
        {10{32'h000fffff}},
        32'h00ffffff,
        32'h000fffff
    };

    // Router FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/mm_router_if.sv
// Bus bundle between the CPU master, the router and the slave ports.
// "slave" is the router's view (it serves the CPU), "master" is the view of
// whatever drives the CPU side and models the slaves.
interface mm_router_if #(
    parameter int NSLV = 12
);
    // CPU side
    logic [31:0]        m_addr;
    logic [31:0]        m_wdata;
    logic               m_rd;
    logic               m_wr;
    logic [31:0]        m_rdata;
    logic               m_ready;
    logic               m_err;
    logic               m_busy;

    // Slave side
    logic [NSLV-1:0]    s_sel;
    logic [31:0]        s_addr;
    logic [31:0]        s_wdata;
    logic               s_rd;
    logic               s_wr;
    logic [NSLV*32-1:0] s_rdata;
    logic [NSLV-1:0]    s_ack;

    modport slave (
        input  m_addr, m_wdata, m_rd, m_wr, s_rdata, s_ack,
        output m_rdata, m_ready, m_err, m_busy,
        output s_sel, s_addr, s_wdata, s_rd, s_wr
    );

    modport master (
        output m_addr, m_wdata, m_rd, m_wr, s_rdata, s_ack,
        input  m_rdata, m_ready, m_err, m_busy,
        input  s_sel, s_addr, s_wdata, s_rd, s_wr
    );

endinterface

// File: rtl/mm_decode.sv
// Combinational address decoder: matches an address against the base/mask
// table and returns the lowest matching slave index, a hit flag and a
// one-hot select.
module mm_decode
    import mm_router_pkg::*;
#(
    parameter int                 NSLV     = MM_NSLV_DEF,
    parameter logic [NSLV*32-1:0] MAP_BASE = MM_DEF_BASE,
    parameter logic [NSLV*32-1:0] MAP_MASK = MM_DEF_MASK
) (
    input  logic [31:0]     addr,
    output logic [3:0]      idx,
    output logic            hit,
    output logic [NSLV-1:0] sel
);

    logic [NSLV-1:0] match;

    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_match
            assign match[gi] =
                ((addr & ~MAP_MASK[32*gi +: 32]) == MAP_BASE[32*gi +: 32]);
        end
    endgenerate

    // Priority pick: scan from the top so the lowest matching index wins.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        sel = '0;
        for (int i = NSLV - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx    = i[3:0];
                hit    = 1'b1;
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mm_router.sv
// Registered memory-map router: decodes a CPU access, drives one slave until
// it acks (or times out), then reports a one-cycle completion with read data
// and an error qualifier. Unmapped and rd+wr accesses are errors that never
// touch a slave.
module mm_router
    import mm_router_pkg::*;
#(
    parameter int                 NSLV     = MM_NSLV_DEF,
    parameter logic [NSLV*32-1:0] MAP_BASE = MM_DEF_BASE,
    parameter logic [NSLV*32-1:0] MAP_MASK = MM_DEF_MASK,
    parameter int                 TIMEOUT  = 255,
    parameter int                 TW       = 16
) (
    input  logic        clk,
    input  logic        rst,
    mm_router_if.slave  bus
);

    state_t             state_reg;
    logic [TW-1:0]      cnt_reg;
    logic [31:0]        m_rdata_reg;
    logic               m_ready_reg;
    logic               m_err_reg;
    logic               m_busy_reg;
    logic [NSLV-1:0]    s_sel_reg;
    logic [31:0]        s_addr_reg;
    logic [31:0]        s_wdata_reg;
    logic               s_rd_reg;
    logic               s_wr_reg;

    logic [3:0]         dec_idx;
    logic               dec_hit;
    logic [NSLV-1:0]    dec_sel;
    logic [31:0]        mask_sel;
    logic [31:0]        rdata_sel;
    logic               ack_sel;
    logic [31:0]        rdata_slot [NSLV];

    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

    mm_decode #(
        .NSLV     (NSLV),
        .MAP_BASE (MAP_BASE),
        .MAP_MASK (MAP_MASK)
    ) u_decode (
        .addr (bus.m_addr),
        .idx  (dec_idx),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    generate
        for (genvar gi = 0; gi < NSLV; gi++) begin : g_slot
            assign rdata_slot[gi] = bus.s_rdata[32*gi +: 32];
        end
    endgenerate

    // Offset mask of the slave currently being decoded.
    always_comb begin
        mask_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (dec_idx == i[3:0]) begin
                mask_sel = MAP_MASK[32*i +: 32];
            end
        end
    end

    // Read data of the selected slave; the select is one-hot so AND-OR is enough.
    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (s_sel_reg[i]) begin
                rdata_sel = rdata_sel | rdata_slot[i];
            end
        end
    end

    // Acks from slaves that are not selected are masked off here.
    assign ack_sel = |(bus.s_ack & s_sel_reg);

    // Transaction FSM with all bus outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            m_rdata_reg <= '0;
            m_ready_reg <= 1'b0;
            m_err_reg   <= 1'b0;
            m_busy_reg  <= 1'b0;
            s_sel_reg   <= '0;
            s_addr_reg  <= '0;
            s_wdata_reg <= '0;
            s_rd_reg    <= 1'b0;
            s_wr_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    m_ready_reg <= 1'b0;
                    m_err_reg   <= 1'b0;
                    m_rdata_reg <= '0;
                    cnt_reg     <= '0;
                    if (bus.m_rd && bus.m_wr) begin
                        // Conflicting direction: answer with an error only.
                        state_reg   <= ST_RESP;
                        m_ready_reg <= 1'b1;
                        m_err_reg   <= 1'b1;
                    end else if (bus.m_rd || bus.m_wr) begin
                        if (dec_hit) begin
                            state_reg   <= ST_ACCESS;
                            m_busy_reg  <= 1'b1;
                            s_sel_reg   <= dec_sel;
                            s_addr_reg  <= bus.m_addr & mask_sel;
                            s_wdata_reg <= bus.m_wdata;
                            s_rd_reg    <= bus.m_rd;
                            s_wr_reg    <= bus.m_wr;
                        end else begin
                            state_reg   <= ST_RESP;
                            m_ready_reg <= 1'b1;
                            m_err_reg   <= 1'b1;
                        end
                    end
                end

                ST_ACCESS: begin
                    if (ack_sel || (cnt_reg == CNT_LAST)) begin
                        // An ack in the last allowed cycle still counts as success.
                        state_reg   <= ST_RESP;
                        m_ready_reg <= 1'b1;
                        m_err_reg   <= !ack_sel;
                        m_rdata_reg <= (ack_sel && s_rd_reg) ? rdata_sel : 32'd0;
                        m_busy_reg  <= 1'b0;
                        s_sel_reg   <= '0;
                        s_addr_reg  <= '0;
                        s_wdata_reg <= '0;
                        s_rd_reg    <= 1'b0;
                        s_wr_reg    <= 1'b0;
                        cnt_reg     <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + TW'(1);
                    end
                end

                ST_RESP: begin
                    state_reg   <= ST_IDLE;
                    m_ready_reg <= 1'b0;
                    m_err_reg   <= 1'b0;
                    m_rdata_reg <= '0;
                    cnt_reg     <= '0;
                end

                default: begin
                    state_reg   <= ST_IDLE;
                    m_ready_reg <= 1'b0;
                    m_err_reg   <= 1'b0;
                    m_rdata_reg <= '0;
                    m_busy_reg  <= 1'b0;
                    s_sel_reg   <= '0;
                    s_addr_reg  <= '0;
                    s_wdata_reg <= '0;
                    s_rd_reg    <= 1'b0;
                    s_wr_reg    <= 1'b0;
                    cnt_reg     <= '0;
                end
            endcase
        end
    end

    assign bus.m_rdata = m_rdata_reg;
    assign bus.m_ready = m_ready_reg;
    assign bus.m_err   = m_err_reg;
    assign bus.m_busy  = m_busy_reg;
    assign bus.s_sel   = s_sel_reg;
    assign bus.s_addr  = s_addr_reg;
    assign bus.s_wdata = s_wdata_reg;
    assign bus.s_rd    = s_rd_reg;
    assign bus.s_wr    = s_wr_reg;

endmodule
